// File: rtl/eth_vlg_tmo_sched.sv
// Shared timeout scheduler: one prescaler tick drives N independent
// down-counting channels, each with a sticky timeout flag and an overflow pulse.
module eth_vlg_tmo_sched #(
  parameter int N     = 4,
  parameter int TICKS = 125000,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] arm,
  input  logic [W-1:0] arm_val,
  input  logic [N-1:0] disarm,
  input  logic [N-1:0] tmo_ack,
  output logic         tick,
  output logic [N-1:0] active,
  output logic [N-1:0] tmo,
  output logic [N-1:0] ovf
);

  localparam int PW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [PW-1:0] CTR_LAST = PW'(TICKS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  logic [PW-1:0] ctr_reg;
  logic          tick_reg;
  logic          strobe;
  logic [W-1:0]  load_val;

  assign strobe   = en && (ctr_reg == CTR_LAST);
  assign load_val = (arm_val == '0) ? W'(1) : arm_val;
  assign tick     = tick_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctr_reg  <= '0;
      tick_reg <= 1'b0;
    end else begin
      tick_reg <= strobe;
      if (en) begin
        ctr_reg <= (ctr_reg == CTR_LAST) ? '0 : ctr_reg + PW'(1);
      end
    end
  end

  state_t       state_reg  [N];
  state_t       state_next [N];
  logic [W-1:0] cnt_reg    [N];
  logic [W-1:0] cnt_next   [N];
  logic         tmo_reg    [N];
  logic         tmo_next   [N];
  logic         ovf_reg    [N];
  logic         ovf_next   [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ch
      logic expire;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_reg[gi] <= IDLE;
          cnt_reg[gi]   <= '0;
          tmo_reg[gi]   <= 1'b0;
          ovf_reg[gi]   <= 1'b0;
        end else begin
          state_reg[gi] <= state_next[gi];
          cnt_reg[gi]   <= cnt_next[gi];
          tmo_reg[gi]   <= tmo_next[gi];
          ovf_reg[gi]   <= ovf_next[gi];
        end
      end

      // disarm beats arm beats the tick; an arm/disarm on the strobe swallows that expiry
      always_comb begin
        state_next[gi] = state_reg[gi];
        cnt_next[gi]   = cnt_reg[gi];
        expire         = 1'b0;
        if (disarm[gi]) begin
          state_next[gi] = IDLE;
          cnt_next[gi]   = '0;
        end else if (arm[gi]) begin
          state_next[gi] = RUN;
          cnt_next[gi]   = load_val;
        end else if (state_reg[gi] == RUN && strobe) begin
          if (cnt_reg[gi] > W'(1)) begin
            cnt_next[gi] = cnt_reg[gi] - W'(1);
          end else begin
            state_next[gi] = IDLE;
            cnt_next[gi]   = '0;
            expire         = 1'b1;
          end
        end
      end

      // a same-cycle ack consumes the previous event, so it suppresses overflow
      always_comb begin
        tmo_next[gi] = tmo_reg[gi];
        ovf_next[gi] = 1'b0;
        if (expire) begin
          tmo_next[gi] = 1'b1;
          ovf_next[gi] = tmo_reg[gi] && !tmo_ack[gi];
        end else if (tmo_ack[gi]) begin
          tmo_next[gi] = 1'b0;
        end
      end

      assign active[gi] = (state_reg[gi] == RUN);
      assign tmo[gi]    = tmo_reg[gi];
      assign ovf[gi]    = ovf_reg[gi];
    end
  endgenerate

endmodule

// File: doc/eth_vlg_tmo_sched.md
Name: eth_vlg_tmo_sched

Overview:
Shared timeout scheduler for protocol engines (ARP, DHCP, TCP retransmit, keep-alive). One prescaler generates a common tick every TICKS enabled clocks. N independent channels count that tick down from a loaded value. On expiry a channel raises a sticky timeout flag, which holds until its owner acknowledges it. This replaces per-engine timer instances with a single shared tick source.

Parameters:
N, 4, number of timeout channels (1..32)
TICKS, 125000, enabled clocks per tick (>=2); prescaler width $clog2(TICKS)
W, 16, width of per-channel tick counter and load value

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
en  in  1  prescaler enable; prescaler holds its count when low
arm  in  N  per-channel load/restart strobe
arm_val  in  W  tick count loaded by every channel whose arm bit is set this cycle
disarm  in  N  per-channel cancel strobe
tmo_ack  in  N  per-channel acknowledge; clears tmo
tick  out  1  registered one-cycle pulse, one cycle after each internal strobe
active  out  N  channel is counting (RUN)
tmo  out  N  sticky expiry flag
ovf  out  N  one-cycle pulse: expiry occurred while tmo was still set

Behaviour:
- Reset (rst=0, async): prescaler=0; every channel goes to IDLE with cnt=0; tick, active, tmo, ovf are all 0.
- Prescaler: when en=1, counts 0..TICKS-1 and wraps to 0; when en=0, holds.
- Strobe: s = en & (ctr==TICKS-1), internal and combinational. tick <= s.
- Channel FSM, two states:
  - IDLE: active=0.
  - RUN: active=1; cnt holds the remaining ticks.
- Per-channel priority each cycle: disarm > arm > decrement.
  - disarm: go to IDLE, cnt=0. A pending tmo is not cleared.
  - arm: go to RUN, cnt = (arm_val==0) ? 1 : arm_val. This applies in both IDLE and RUN; in RUN it is a restart.
  - RUN & s & cnt>1: cnt <= cnt-1.
  - RUN & s & cnt==1: expiry. Go to IDLE, cnt=0, set tmo.
- Expiry latency: tmo and active change on the clock edge where s=1. They are visible the following cycle, the same cycle as tick.
- Armed with value V on a cycle without s, a channel expires on the V-th subsequent strobe. If arm coincides with s, that strobe is not counted.
- Arm or disarm in the same cycle as an expiry strobe: the expiry is suppressed, with no tmo and no ovf.
- tmo update:
  - Expiry has priority over tmo_ack in the same cycle: tmo stays 1 and ovf stays 0 (the ack consumed the old event).
  - Expiry while tmo=1 and no ack that cycle: ovf pulses for 1 cycle and tmo stays 1.
  - tmo_ack with no expiry: tmo <= 0.
  - tmo_ack while tmo=0: no effect.
- Channels are fully independent. Any number may expire on the same strobe.
- en=0 freezes all channel counts. arm, disarm and tmo_ack are still honoured.
- Counter arithmetic is unsigned W-bit, with no underflow path because cnt never decrements from 1. arm_val = 2^W-1 is legal.

Test Plan:
- Bench configuration: N=4, TICKS=4, W=8, en=1.
- Reset mid-run: arm ch1 with 5, assert rst=0 asynchronously after 2 strobes -> active, tmo, ovf and tick are 0 immediately. After release, the first tick comes 4 clocks later and ch1 never expires.
- Basic expiry: arm ch0 with arm_val=3 at prescaler=0 -> active[0]=1. tmo[0] rises 12 clocks after arm, together with tick. active[0] falls the same cycle. tmo[0] holds until tmo_ack[0], then clears the next cycle.
- Restart and cancel: arm ch2 with 4; after 2 ticks re-arm with 4 -> expiry only after 4 more ticks. Arm ch3 with 2 and disarm after 1 tick -> tmo[3] never rises and active[3]=0.
- Overflow: arm ch1 with 1 and leave tmo[1] unacked; re-arm with 1 -> ovf[1] pulses for one cycle at the second expiry and tmo[1]=1. Repeat with tmo_ack[1] on the expiry cycle -> tmo[1]=1 and ovf[1]=0.
- Collisions: arm ch0 with arm_val=0 -> expires on the first strobe. Arm ch2 with 2 in the same cycle as the strobe that would expire it -> no tmo, and expiry after 2 further ticks. Arm all 4 channels with 2 simultaneously -> tmo=4'b1111 on the same cycle.
- Freeze: arm ch0 with 2, drop en for 10 clocks after 1 tick -> no tick and counts hold. After en returns, the expiry comes exactly 1 tick later.
